// File: rtl/ctrl_path_if.sv
// Bundles the assembly-buffer, FIFO, counter, state, inverse-data and event signals of ctrl_path_unit.
// master is the driving/consuming side, slave is the unit itself.
interface ctrl_path_if;
    logic [7:0]  data_in;
    logic        load_data;
    logic        write_on_fifo;
    logic        fifo1_full;
    logic        fifo2_full;
    logic        control_sig;
    logic        change_fsm_state;
    logic        en_fsm;
    logic        counter_en;
    logic [31:0] inv_data_in;
    logic        inv_data_en_pulse;
    logic [31:0] data_fifo1;
    logic [7:0]  data_fifo2;
    logic [7:0]  buffer_lsw;
    logic        write_en;
    logic [7:0]  count_out_control;
    logic        control_counter;
    logic        control_state;
    logic        error_sig;
    logic [31:0] inv_data_out;
    logic [2:0]  interruption_code;
    logic        interruption_valid;

    modport master (
        output data_in, load_data, write_on_fifo, fifo1_full, fifo2_full, control_sig,
               change_fsm_state, en_fsm, counter_en, inv_data_in, inv_data_en_pulse,
        input  data_fifo1, data_fifo2, buffer_lsw, write_en, count_out_control,
               control_counter, control_state, error_sig, inv_data_out,
               interruption_code, interruption_valid
    );

    modport slave (
        input  data_in, load_data, write_on_fifo, fifo1_full, fifo2_full, control_sig,
               change_fsm_state, en_fsm, counter_en, inv_data_in, inv_data_en_pulse,
        output data_fifo1, data_fifo2, buffer_lsw, write_en, count_out_control,
               control_counter, control_state, error_sig, inv_data_out,
               interruption_code, interruption_valid
    );
endinterface

// File: rtl/ctrl_path_unit.sv
// Control-path unit: byte assembly buffer feeding two FIFOs, overflow error flag,
// wrap counter, IDLE/ACTIVE toggle state, inverse-data capture and prioritised event pulses.
module ctrl_path_unit (
    input  logic       clk_control,
    input  logic       rst_n_fsm,
    ctrl_path_if.slave bus
);
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [31:0] buffer_q, buffer_d;
    logic [7:0]  count_q, count_d;
    logic        ctrl_cnt_q, ctrl_cnt_d;
    state_t      state_q, state_d;
    logic        error_q, error_d;
    logic [31:0] inv_q, inv_d;
    logic [2:0]  code_q, code_d;
    logic        valid_q, valid_d;

    logic overflow;
    logic wrap;
    logic toggle;
    logic err_rise;

    always_comb begin
        overflow = bus.write_on_fifo & (bus.fifo1_full | bus.fifo2_full);
        wrap     = bus.counter_en & (count_q == 8'hFF);
        toggle   = bus.change_fsm_state & bus.en_fsm;
        err_rise = overflow & ~error_q;

        buffer_d   = bus.load_data ? {buffer_q[23:0], bus.data_in} : buffer_q;
        count_d    = bus.counter_en ? count_q + 8'd1 : count_q;
        ctrl_cnt_d = wrap;
        inv_d      = bus.inv_data_en_pulse ? ~bus.inv_data_in : inv_q;

        state_d = state_q;
        if (toggle) begin
            state_d = (state_q == IDLE) ? ACTIVE : IDLE;
        end

        // A new overflow outranks a simultaneous clear.
        error_d = error_q;
        if (overflow) begin
            error_d = 1'b1;
        end else if (bus.control_sig) begin
            error_d = 1'b0;
        end

        // One pulse per cycle; lower-priority causes in the same cycle are dropped.
        code_d  = code_q;
        valid_d = 1'b0;
        if (err_rise) begin
            code_d  = 3'b001;
            valid_d = 1'b1;
        end else if (wrap) begin
            code_d  = 3'b010;
            valid_d = 1'b1;
        end else if (toggle) begin
            code_d  = 3'b100;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_control or negedge rst_n_fsm) begin
        if (!rst_n_fsm) begin
            buffer_q   <= '0;
            count_q    <= '0;
            ctrl_cnt_q <= 1'b0;
            state_q    <= IDLE;
            error_q    <= 1'b0;
            inv_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            buffer_q   <= buffer_d;
            count_q    <= count_d;
            ctrl_cnt_q <= ctrl_cnt_d;
            state_q    <= state_d;
            error_q    <= error_d;
            inv_q      <= inv_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
        end
    end

    // The FIFOs sample on the same edge as the shift, so they see the pre-shift buffer.
    assign bus.write_en           = bus.write_on_fifo & ~bus.fifo1_full & ~bus.fifo2_full;
    assign bus.data_fifo1         = buffer_q;
    assign bus.data_fifo2         = buffer_q[7:0];
    assign bus.buffer_lsw         = buffer_q[7:0];
    assign bus.count_out_control  = count_q;
    assign bus.control_counter    = ctrl_cnt_q;
    assign bus.control_state      = (state_q == ACTIVE);
    assign bus.error_sig          = error_q;
    assign bus.inv_data_out       = inv_q;
    assign bus.interruption_code  = code_q;
    assign bus.interruption_valid = valid_q;
endmodule

// File: tb/tb_ctrl_path_unit.sv
// Randomised scoreboard bench for ctrl_path_unit with a byte-queue / integer reference model.
module tb_ctrl_path_unit;
    logic clk_control = 1'b0;
    logic rst_n_fsm   = 1'b0;

    ctrl_path_if bus ();

    ctrl_path_unit dut (
        .clk_control (clk_control),
        .rst_n_fsm   (rst_n_fsm),
        .bus         (bus)
    );

    always #5 clk_control = ~clk_control;

    int checks = 0;
    int errors = 0;

    // Reference model state (value after the most recent edge).
    logic [7:0]  m_bytes[$];
    int          m_cnt;
    bit          m_cc, m_st, m_err, m_vld;
    logic [31:0] m_inv;
    logic [2:0]  m_code;

    logic [31:0] wq[$];
    logic [2:0]  iq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_buf();
        return {m_bytes[0], m_bytes[1], m_bytes[2], m_bytes[3]};
    endfunction

    task automatic model_reset();
        m_bytes.delete();
        repeat (4) m_bytes.push_back(8'h00);
        m_cnt = 0; m_cc = 0; m_st = 0; m_err = 0; m_vld = 0;
        m_inv = '0; m_code = '0;
        wq.delete();
        iq.delete();
    endtask

    task automatic drive_idle();
        bus.data_in = '0; bus.load_data = 0; bus.write_on_fifo = 0;
        bus.fifo1_full = 0; bus.fifo2_full = 0; bus.control_sig = 0;
        bus.change_fsm_state = 0; bus.en_fsm = 0; bus.counter_en = 0;
        bus.inv_data_in = '0; bus.inv_data_en_pulse = 0;
    endtask

    task automatic check_state();
        logic [31:0] b;
        b = model_buf();
        chk("data_fifo1", bus.data_fifo1, b);
        chk("buffer_lsw", {24'h0, bus.buffer_lsw}, {24'h0, b[7:0]});
        chk("data_fifo2", {24'h0, bus.data_fifo2}, {24'h0, b[7:0]});
        chk("count", {24'h0, bus.count_out_control}, m_cnt);
        chk("control_counter", {31'h0, bus.control_counter}, {31'h0, m_cc});
        chk("control_state", {31'h0, bus.control_state}, {31'h0, m_st});
        chk("error_sig", {31'h0, bus.error_sig}, {31'h0, m_err});
        chk("inv_data_out", bus.inv_data_out, m_inv);
        chk("int_code", {29'h0, bus.interruption_code}, {29'h0, m_code});
        chk("int_valid", {31'h0, bus.interruption_valid}, {31'h0, m_vld});
    endtask

    // One clock cycle: check the post-edge state, drive new inputs, advance the model.
    task automatic step(input bit ld, input logic [7:0] d, input bit wr, input bit f1, input bit f2,
                        input bit cs, input bit chg, input bit en, input bit cen,
                        input logic [31:0] inv, input bit pulse);
        bit ovf, wrp, tog, rise;
        @(posedge clk_control); #1;
        check_state();
        bus.data_in = d; bus.load_data = ld; bus.write_on_fifo = wr;
        bus.fifo1_full = f1; bus.fifo2_full = f2; bus.control_sig = cs;
        bus.change_fsm_state = chg; bus.en_fsm = en; bus.counter_en = cen;
        bus.inv_data_in = inv; bus.inv_data_en_pulse = pulse;

        if (wr && !f1 && !f2) wq.push_back(model_buf());
        ovf  = wr && (f1 || f2);
        wrp  = cen && (m_cnt == 255);
        tog  = chg && en;
        rise = ovf && !m_err;
        if (ld) begin
            m_bytes.push_back(d);
            void'(m_bytes.pop_front());
        end
        if (cen) m_cnt = (m_cnt + 1) % 256;
        m_cc = wrp;
        if (tog) m_st = !m_st;
        if (ovf) m_err = 1;
        else if (cs) m_err = 0;
        if (pulse) m_inv = ~inv;
        m_vld = rise || wrp || tog;
        if (rise) m_code = 3'b001;
        else if (wrp) m_code = 3'b010;
        else if (tog) m_code = 3'b100;
        if (m_vld) iq.push_back(m_code);
    endtask

    task automatic idle();
        step(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    endtask

    task automatic apply_reset();
        rst_n_fsm = 1'b0;
        #1;
        chk("rst_buf", bus.data_fifo1, 32'h0);
        chk("rst_count", {24'h0, bus.count_out_control}, 32'h0);
        chk("rst_cc", {31'h0, bus.control_counter}, 32'h0);
        chk("rst_state", {31'h0, bus.control_state}, 32'h0);
        chk("rst_err", {31'h0, bus.error_sig}, 32'h0);
        chk("rst_inv", bus.inv_data_out, 32'h0);
        chk("rst_code", {29'h0, bus.interruption_code}, 32'h0);
        chk("rst_valid", {31'h0, bus.interruption_valid}, 32'h0);
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk_control);
        @(negedge clk_control);
        rst_n_fsm = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a push or an event.
    always @(negedge clk_control) begin
        if (rst_n_fsm) begin
            if (bus.write_en) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write_en", {31'h0, bus.write_en}, 32'h0);
                end else begin
                    logic [31:0] w;
                    w = wq.pop_front();
                    chk("push_fifo1", bus.data_fifo1, w);
                    chk("push_fifo2", {24'h0, bus.data_fifo2}, {24'h0, w[7:0]});
                end
            end else if (wq.size() != 0) begin
                chk("missing_write_en", {31'h0, bus.write_en}, 32'h1);
                void'(wq.pop_front());
            end
            if (bus.interruption_valid) begin
                if (iq.size() == 0) begin
                    chk("unexpected_int_valid", {31'h0, bus.interruption_valid}, 32'h0);
                end else begin
                    logic [2:0] c;
                    c = iq.pop_front();
                    chk("event_code", {29'h0, bus.interruption_code}, {29'h0, c});
                end
            end
        end
    end

    initial begin
        drive_idle();
        model_reset();
        apply_reset();

        // Full counter lap from reset.
        repeat (256) step(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
        idle();
        chk("wrap_count", {24'h0, bus.count_out_control}, 32'h0);
        chk("wrap_cc", {31'h0, bus.control_counter}, 32'h1);
        chk("wrap_code", {29'h0, bus.interruption_code}, 32'h2);
        chk("wrap_valid", {31'h0, bus.interruption_valid}, 32'h1);
        idle();
        chk("wrap_cc_drop", {31'h0, bus.control_counter}, 32'h0);

        // Assemble a word and push it.
        step(1, 8'h11, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        step(1, 8'h22, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        step(1, 8'h33, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        step(1, 8'h44, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        step(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        #2;
        chk("push_we", {31'h0, bus.write_en}, 32'h1);
        chk("push_word", bus.data_fifo1, 32'h11223344);
        chk("push_byte", {24'h0, bus.data_fifo2}, 32'h44);
        idle();
        #2;
        chk("push_we_single", {31'h0, bus.write_en}, 32'h0);

        // Overflow into a full FIFO2, then clear.
        step(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 32'h0, 0);
        #2;
        chk("ovf_we", {31'h0, bus.write_en}, 32'h0);
        step(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
        chk("ovf_err", {31'h0, bus.error_sig}, 32'h1);
        chk("ovf_code", {29'h0, bus.interruption_code}, 32'h1);
        chk("ovf_valid", {31'h0, bus.interruption_valid}, 32'h1);
        idle();
        chk("clr_err", {31'h0, bus.error_sig}, 32'h0);
        chk("clr_valid", {31'h0, bus.interruption_valid}, 32'h0);
        chk("code_hold", {29'h0, bus.interruption_code}, 32'h1);

        // Overflow and clear together: set wins.
        step(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 32'h0, 0);
        idle();
        chk("set_wins", {31'h0, bus.error_sig}, 32'h1);
        step(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0);

        // State toggle only when enabled.
        step(0, 8'h00, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
        idle();
        chk("no_toggle", {31'h0, bus.control_state}, 32'h0);
        step(0, 8'h00, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0);
        idle();
        chk("toggle_state", {31'h0, bus.control_state}, 32'h1);
        chk("toggle_code", {29'h0, bus.interruption_code}, 32'h4);
        chk("toggle_valid", {31'h0, bus.interruption_valid}, 32'h1);

        // Inverse capture and hold.
        step(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h0000FFFF, 1);
        idle();
        chk("inv_capture", bus.inv_data_out, 32'hFFFF0000);
        step(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 32'h12345678, 0);
        idle();
        chk("inv_hold", bus.inv_data_out, 32'hFFFF0000);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 50, 8'($urandom), $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 70,
                 $urandom, $urandom_range(0, 99) < 20);
        end

        // Asynchronous reset mid-load with the counter at 0x7F.
        @(posedge clk_control); #1;
        drive_idle();
        rst_n_fsm = 1'b0;
        #1;
        model_reset();
        rst_n_fsm = 1'b1;
        for (int i = 0; i < 127; i++) step(1, 8'($urandom), 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
        step(1, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
        chk("pre_rst_count", {24'h0, bus.count_out_control}, 32'h7F);
        #2;
        apply_reset();

        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom, $urandom_range(0, 99) < 20);
        end
        idle();
        idle();
        @(negedge clk_control); #1;
        chk("wq_drained", wq.size(), 32'h0);
        chk("iq_drained", iq.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ctrl_path_unit.md
CTRL_PATH_UNIT -- requirements
Module: ctrl_path_unit

Interface
REQ-001 Reset is rst_n_fsm, asynchronous, active-low; clock is clk_control; all state updates on the rising edge of clk_control.
REQ-002 clk_control  input  1  sole clock.
REQ-003 rst_n_fsm  input  1  asynchronous active-low reset.
REQ-004 data_in  input  8  byte loaded into the assembly buffer.
REQ-005 load_data  input  1  shift data_in into the buffer this cycle.
REQ-006 write_on_fifo  input  1  request to push the buffer to both downstream FIFOs.
REQ-007 fifo1_full, fifo2_full  input  1 each  downstream FIFO full flags, same clock domain.
REQ-008 control_sig  input  1  clears sticky error_sig.
REQ-009 change_fsm_state  input  1  toggle request for control_state.
REQ-010 en_fsm  input  1  qualifies change_fsm_state.
REQ-011 counter_en  input  1  increment enable for count_out_control.
REQ-012 inv_data_in  input  32  data returned from the consumer.
REQ-013 inv_data_en_pulse  input  1  single-cycle capture strobe for inv_data_in.
REQ-014 data_fifo1  output  32  full assembly buffer (FIFO1 write data).
REQ-015 data_fifo2  output  8  buffer least-significant byte (FIFO2 write data).
REQ-016 buffer_lsw  output  8  buffer least-significant byte.
REQ-017 write_en  output  1  push strobe to both FIFOs.
REQ-018 count_out_control  output  8  event counter.
REQ-019 control_counter  output  1  one-cycle counter wrap pulse.
REQ-020 control_state  output  1  state bit: 0 IDLE, 1 ACTIVE.
REQ-021 error_sig  output  1  sticky overflow error.
REQ-022 inv_data_out  output  32  bitwise inverse of last captured inv_data_in.
REQ-023 interruption_code  output  3  event code; interruption_valid  output  1  event strobe.

Function
REQ-024 Buffer: 32-bit register; when load_data=1, buf <= {buf[23:0], data_in}; otherwise it holds.
REQ-025 data_fifo1 = buf; data_fifo2 = buffer_lsw = buf[7:0], combinational from the register.
REQ-026 write_en = write_on_fifo & ~fifo1_full & ~fifo2_full, combinational; FIFOs sample data_fifo1/2 on the same edge.
REQ-027 load_data and write_on_fifo in the same cycle: write_en pushes the pre-shift buffer value; the shift takes effect after that edge.
REQ-028 Overflow: write_on_fifo=1 while either full flag is 1 sets error_sig on the next edge; error_sig stays set until control_sig=1.
REQ-029 Same-cycle overflow and control_sig: set wins; error_sig remains 1.
REQ-030 Counter: count_out_control increments by 1 when counter_en=1 and wraps 255->0; otherwise it holds.
REQ-031 control_counter is 1 for exactly the cycle after a 255->0 wrap, else 0.
REQ-032 State: control_state toggles (IDLE<->ACTIVE) on an edge where change_fsm_state=1 and en_fsm=1; otherwise it holds.
REQ-033 inv_data_out <= ~inv_data_in on an edge with inv_data_en_pulse=1; otherwise it holds.
REQ-034 Events, registered, one-cycle interruption_valid pulse the cycle after the cause:
- error_sig 0->1 transition: code 3'b001.
- counter wrap: code 3'b010.
- state toggle: code 3'b100.
REQ-035 Simultaneous events: priority error > wrap > state; a single pulse is issued and lower-priority events in that cycle are dropped.
REQ-036 interruption_code holds its last value while interruption_valid=0.

Reset
REQ-037 While rst_n_fsm=0, immediately and asynchronously: buf=0, count_out_control=0, control_counter=0, control_state=0, error_sig=0, inv_data_out=0, interruption_code=0, interruption_valid=0.
REQ-038 write_en follows REQ-026 during reset; a mid-operation reset discards the buffer and any pending event.
REQ-039 Reset release is synchronised externally; first state update is on the first rising edge after rst_n_fsm goes high.

Verification
REQ-040 Load 0x11, 0x22, 0x33, 0x44 (4 cycles), then write_on_fifo=1 with both FIFOs not full -> data_fifo1=0x11223344, data_fifo2=0x44, write_en=1 for 1 cycle.
REQ-041 fifo2_full=1 and write_on_fifo=1 -> write_en=0, error_sig=1 next cycle, code 3'b001 with valid for 1 cycle; control_sig=1 -> error_sig=0.
REQ-042 counter_en=1 for 256 cycles from reset -> count_out_control back to 0, control_counter=1 for 1 cycle, code 3'b010 with valid pulse.
REQ-043 change_fsm_state=1 with en_fsm=0 -> no change; with en_fsm=1 -> control_state 0->1, code 3'b100 with valid pulse.
REQ-044 inv_data_in=0x0000FFFF with pulse -> inv_data_out=0xFFFF0000, held after the pulse.
REQ-045 Assert rst_n_fsm=0 mid-load with the counter at 0x7F -> all registered outputs 0 without waiting for a clock edge.
